bcd_counter_nd: RTL and testbench
=================================

BCD_COUNTER_ND -- requirements
Module: bcd_counter_nd

Interface
REQ-001 SHALL have parameter DIGITS, default 3: number of BCD digits (1..8); digit 0 is least significant.
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 0: 1 inverts every segment output bit.
REQ-003 SHALL have one clock, clk, and reset is synchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up_dn  input  1  count direction: 1 = up, 0 = down.
REQ-008 SHALL have port load  input  1  parallel load strobe.
REQ-009 SHALL have port load_val  input  4*DIGITS  BCD load value; digit k occupies bits [4k+3:4k].
REQ-010 SHALL have port count  output  4*DIGITS  registered BCD count, same packing as load_val.
REQ-011 SHALL have port seg  output  7*DIGITS  registered segment outputs; digit k occupies bits [7k+6:7k], ordered {a,b,c,d,e,f,g} MSB first.
REQ-012 SHALL have port tc  output  1  terminal-count (wrap) pulse.
REQ-013 SHALL have port err  output  1  rejected-load pulse.

Function
REQ-014 SHALL apply per-edge priority: reset low, then load, then en; with none active, count SHALL hold.
REQ-015 SHALL, on load with every load_val digit <= 9, write count = load_val on that edge; tc = 0, err = 0.
REQ-016 SHALL, on load with any load_val digit > 9, leave count unchanged and set err = 1 for exactly one cycle; no count occurs that cycle even if en = 1.
REQ-017 SHALL, when counting up with en = 1: increment digit 0; a digit at 9 becomes 0 and carries to the next digit, rippling through all digits within one cycle.
REQ-018 SHALL, when counting down with en = 1: decrement digit 0; a digit at 0 becomes 9 and borrows from the next digit, rippling within one cycle.
REQ-019 SHALL, counting up from all-9s, wrap count to all-0s and set tc = 1 on that same edge.
REQ-020 SHALL, counting down from all-0s, wrap count to all-9s and set tc = 1 on that same edge.
REQ-021 SHALL hold tc = 1 for one cycle per wrap; tc SHALL be 0 in every other cycle, including load and hold cycles.
REQ-022 SHALL allow up_dn to change on any cycle, taking effect on the next enabled edge, with no extra latency.
REQ-023 SHALL update seg one cycle after count; seg in cycle n+1 decodes count from cycle n.
REQ-024 SHALL decode each digit as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, any other value=1001111 ("E").
REQ-025 SHALL output the bitwise inverse of every REQ-024 pattern when SEG_ACTIVE_LOW = 1.
REQ-026 SHALL never hold a non-BCD digit in count when driven only through reset, load and en.

Reset
REQ-027 SHALL, on an edge with reset = 0, set count = 0, tc = 0 and err = 0, and set seg to the "0" pattern on every digit (inverted per REQ-025).
REQ-028 SHALL let reset override load and en in the same cycle, including mid-ripple and mid-wrap, with no tc or err pulse.
REQ-029 SHALL NOT depend on initial blocks for functional state; the first defined state follows the first reset edge.

Verification (DIGITS=3, SEG_ACTIVE_LOW=0)
REQ-030 SHALL verify: reset low for 1 edge, then en=1, up_dn=1 for 12 edges -> count=012; seg digit0=1101101 and digit1=0110000 one cycle after count shows 012.
REQ-031 SHALL verify: load 998, then en=1, up_dn=1 for 2 edges -> count 999 then 000; tc=1 only in the 000 cycle.
REQ-032 SHALL verify: after reset, en=1, up_dn=0 for 1 edge -> count=999, tc=1 for one cycle; 1 more edge -> 998, tc=0.
REQ-033 SHALL verify: count=045, load=1 with load_val=0x1A3 and en=1 -> count stays 045, err=1 for one cycle, tc=0.
REQ-034 SHALL verify: count=199 with en=1, up_dn=1, and reset=0 on the same edge -> count=000, tc=0, and seg all digits=1111110 on the following cycle.
REQ-035 SHALL verify: load 500, then toggle up_dn every edge with en=1 for 4 edges -> count 501, 500, 501, 500.

Source files
------------

// File: rtl/bcd_counter_nd.sv
// Multi-digit BCD up/down counter with parallel load, wrap pulse and a
// registered seven-segment decode of every digit.
module bcd_counter_nd #(
    parameter int DIGITS         = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tc,
    output logic                  err
);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1111110;
            4'd1:    p = 7'b0110000;
            4'd2:    p = 7'b1101101;
            4'd3:    p = 7'b1111001;
            4'd4:    p = 7'b0110011;
            4'd5:    p = 7'b1011011;
            4'd6:    p = 7'b1011111;
            4'd7:    p = 7'b1110000;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1111011;
            default: p = 7'b1001111;
        endcase
        return SEG_ACTIVE_LOW ? ~p : p;
    endfunction

    logic [4*DIGITS-1:0] count_step;
    logic                wrap;
    logic                load_ok;
    logic [7*DIGITS-1:0] seg_next;
    logic [7*DIGITS-1:0] seg_zero;

    // Ripple carry/borrow across all digits in one cycle; a carry out of the
    // top digit is the wrap condition.
    always_comb begin
        logic       carry;
        logic [3:0] dig;
        count_step = count;
        carry      = 1'b1;
        load_ok    = 1'b1;
        seg_next   = '0;
        seg_zero   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = count[4*k +: 4];
            if (carry) begin
                if (up_dn) begin
                    if (dig >= 4'd9) begin
                        count_step[4*k +: 4] = 4'd0;
                    end else begin
                        count_step[4*k +: 4] = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        count_step[4*k +: 4] = 4'd9;
                    end else begin
                        count_step[4*k +: 4] = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            if (load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
            seg_next[7*k +: 7] = seg_decode(dig);
            seg_zero[7*k +: 7] = seg_decode(4'd0);
        end
        wrap = carry;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            seg   <= seg_zero;
            tc    <= 1'b0;
            err   <= 1'b0;
        end else begin
            tc  <= 1'b0;
            err <= 1'b0;
            seg <= seg_next;
            // A rejected load still blocks counting for that edge.
            if (load) begin
                if (load_ok) count <= load_val;
                else         err   <= 1'b1;
            end else if (en) begin
                count <= count_step;
                tc    <= wrap;
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Directed bench for bcd_counter_nd with DIGITS=3, active-high segments.
module tb_bcd_counter_nd;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        up_dn;
    logic        load;
    logic [11:0] load_val;
    logic [11:0] count;
    logic [20:0] seg;
    logic        tc;
    logic        err;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S9 = 7'b1111011;

    bcd_counter_nd #(.DIGITS(3), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(count), .seg(seg), .tc(tc), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string name, input logic [11:0] exp);
        total++;
        if (count !== exp) begin
            bad++;
            $display("FAIL %s count got=%h exp=%h", name, count, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic exp_tc, input logic exp_err);
        total++;
        if (tc !== exp_tc || err !== exp_err) begin
            bad++;
            $display("FAIL %s tc/err got=%b%b exp=%b%b", name, tc, err, exp_tc, exp_err);
        end
    endtask

    task automatic chk_seg(input string name, input logic [20:0] exp);
        total++;
        if (seg !== exp) begin
            bad++;
            $display("FAIL %s seg got=%b exp=%b", name, seg, exp);
        end
    endtask

    task automatic do_load(input logic [11:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 12'h123;
        step();
        chk_count("reset_count", 12'h000);
        chk_flags("reset_flags", 1'b0, 1'b0);
        chk_seg("reset_seg", {S0, S0, S0});
        reset = 1'b1; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_count_up();
        en = 1'b1; up_dn = 1'b1;
        repeat (12) step();
        chk_count("up12_count", 12'h012);
        chk_flags("up12_flags", 1'b0, 1'b0);
        en = 1'b0;
        step();
        chk_seg("up12_seg", {S0, S1, S2});
        chk_count("up12_hold", 12'h012);
    endtask

    task automatic test_wrap_up();
        do_load(12'h998);
        chk_count("ld998_count", 12'h998);
        chk_flags("ld998_flags", 1'b0, 1'b0);
        en = 1'b1; up_dn = 1'b1;
        step();
        chk_count("wu_999", 12'h999);
        chk_flags("wu_999_flags", 1'b0, 1'b0);
        step();
        chk_count("wu_000", 12'h000);
        chk_flags("wu_000_flags", 1'b1, 1'b0);
        chk_seg("wu_seg999", {S9, S9, S9});
        en = 1'b0;
        step();
        chk_flags("wu_hold_flags", 1'b0, 1'b0);
        chk_count("wu_hold", 12'h000);
    endtask

    task automatic test_wrap_down();
        reset = 1'b0;
        step();
        reset = 1'b1; en = 1'b1; up_dn = 1'b0;
        step();
        chk_count("wd_999", 12'h999);
        chk_flags("wd_999_flags", 1'b1, 1'b0);
        step();
        chk_count("wd_998", 12'h998);
        chk_flags("wd_998_flags", 1'b0, 1'b0);
        en = 1'b0;
    endtask

    task automatic test_bad_load();
        do_load(12'h045);
        chk_count("ld045", 12'h045);
        load = 1'b1; load_val = 12'h1A3; en = 1'b1; up_dn = 1'b1;
        step();
        chk_count("badld_count", 12'h045);
        chk_flags("badld_flags", 1'b0, 1'b1);
        load = 1'b0; en = 1'b0;
        step();
        chk_flags("badld_after", 1'b0, 1'b0);
        chk_count("badld_hold", 12'h045);
    endtask

    task automatic test_reset_override();
        do_load(12'h199);
        chk_count("ld199", 12'h199);
        reset = 1'b0; en = 1'b1; up_dn = 1'b1;
        step();
        chk_count("rov_count", 12'h000);
        chk_flags("rov_flags", 1'b0, 1'b0);
        reset = 1'b1; en = 1'b0;
        step();
        chk_seg("rov_seg", {S0, S0, S0});
        chk_count("rov_hold", 12'h000);
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_seq [4];
        exp_seq[0] = 12'h501; exp_seq[1] = 12'h500;
        exp_seq[2] = 12'h501; exp_seq[3] = 12'h500;
        do_load(12'h500);
        chk_count("ld500", 12'h500);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_dn = (i % 2 == 0);
            step();
            chk_count($sformatf("toggle%0d", i), exp_seq[i]);
            chk_flags($sformatf("toggle%0d_flags", i), 1'b0, 1'b0);
        end
        load = 1'b1; load_val = 12'h321; up_dn = 1'b1;
        step();
        chk_count("load_over_en", 12'h321);
        load = 1'b0; en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_bad_load();
        test_reset_override();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
